// File: rtl/wb_trace_fifo.sv
// Writeback trace FIFO: captures register-file writes and presents them to a consumer
// first-word-fall-through, counting events that arrive while the queue is full.
module wb_trace_fifo #(
  parameter int unsigned DEPTH       = 8,
  parameter bit          FILTER_ZERO = 1'b1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wb_en,
  input  logic [31:0]              wb_pc,
  input  logic [4:0]               wb_addr,
  input  logic [31:0]              wb_data,
  input  logic                     trace_ready,
  output logic                     trace_valid,
  output logic [31:0]              trace_pc,
  output logic [4:0]               trace_addr,
  output logic [31:0]              trace_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty,
  output logic [15:0]              drop_cnt,
  output logic                     overflow
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FullCount = (AW+1)'(DEPTH);

  logic [31:0] mem_pc   [DEPTH];
  logic [4:0]  mem_addr [DEPTH];
  logic [31:0] mem_data [DEPTH];

  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q;
  logic [15:0]   drop_q;
  logic          ovf_q;

  logic capture, push, pop, drop;

  always_comb begin
    capture = wb_en && !(FILTER_ZERO && (wb_addr == 5'd0));
    pop     = trace_valid && trace_ready;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    push    = capture && (!full || pop);
    drop    = capture && full && !pop;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      drop_q   <= '0;
      ovf_q    <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (push && !pop)      count_q <= count_q + 1'b1;
      else if (pop && !push) count_q <= count_q - 1'b1;
      if (drop) begin
        ovf_q <= 1'b1;
        if (drop_q != 16'hFFFF) drop_q <= drop_q + 16'd1;
      end
    end
  end

  // Storage carries no reset; stale contents are hidden behind trace_valid.
  always_ff @(posedge clk) begin
    if (push && !reset) begin
      mem_pc[wr_ptr_q]   <= wb_pc;
      mem_addr[wr_ptr_q] <= wb_addr;
      mem_data[wr_ptr_q] <= wb_data;
    end
  end

  assign full        = (count_q == FullCount);
  assign empty       = (count_q == '0);
  assign count       = count_q;
  assign trace_valid = !empty;
  assign trace_pc    = mem_pc[rd_ptr_q];
  assign trace_addr  = mem_addr[rd_ptr_q];
  assign trace_data  = mem_data[rd_ptr_q];
  assign drop_cnt    = drop_q;
  assign overflow    = ovf_q;

endmodule

// File: tb/tb_wb_trace_fifo.sv
// Directed plus randomized bench for wb_trace_fifo; a queue-based model supplies every
// expected value.
module tb_wb_trace_fifo;
  localparam int DEPTH = 8;

  logic        clk, reset, wb_en, trace_ready;
  logic [31:0] wb_pc, wb_data;
  logic [4:0]  wb_addr;

  logic        trace_valid, full, empty, overflow;
  logic [31:0] trace_pc, trace_data;
  logic [4:0]  trace_addr;
  logic [3:0]  count;
  logic [15:0] drop_cnt;

  logic        nf_valid, nf_full, nf_empty, nf_overflow;
  logic [31:0] nf_pc, nf_data;
  logic [4:0]  nf_addr;
  logic [3:0]  nf_count;
  logic [15:0] nf_drop;

  wb_trace_fifo #(.DEPTH(DEPTH), .FILTER_ZERO(1'b1)) dut (
    .clk(clk), .reset(reset), .wb_en(wb_en), .wb_pc(wb_pc), .wb_addr(wb_addr),
    .wb_data(wb_data), .trace_ready(trace_ready), .trace_valid(trace_valid),
    .trace_pc(trace_pc), .trace_addr(trace_addr), .trace_data(trace_data),
    .count(count), .full(full), .empty(empty), .drop_cnt(drop_cnt), .overflow(overflow)
  );

  wb_trace_fifo #(.DEPTH(DEPTH), .FILTER_ZERO(1'b0)) dut_nf (
    .clk(clk), .reset(reset), .wb_en(wb_en), .wb_pc(wb_pc), .wb_addr(wb_addr),
    .wb_data(wb_data), .trace_ready(trace_ready), .trace_valid(nf_valid),
    .trace_pc(nf_pc), .trace_addr(nf_addr), .trace_data(nf_data),
    .count(nf_count), .full(nf_full), .empty(nf_empty), .drop_cnt(nf_drop),
    .overflow(nf_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  addr;
    logic [31:0] data;
  } ent_t;

  ent_t        q[$];
  logic [15:0] m_drop;
  logic        m_ovf;
  int          n_pass, n_total;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Advance one clock, updating the model from the inputs presented at that edge.
  task automatic cycle();
    ent_t e;
    if (reset) begin
      q.delete();
      m_drop = '0;
      m_ovf  = 1'b0;
    end else begin
      if (trace_ready && q.size() != 0) void'(q.pop_front());
      if (wb_en && wb_addr != 5'd0) begin
        if (q.size() < DEPTH) begin
          e.pc = wb_pc; e.addr = wb_addr; e.data = wb_data;
          q.push_back(e);
        end else begin
          m_ovf = 1'b1;
          if (m_drop != 16'hFFFF) m_drop++;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string tag);
    check({tag, ".valid"}, 64'(trace_valid), 64'(q.size() != 0));
    check({tag, ".count"}, 64'(count), 64'(q.size()));
    check({tag, ".full"},  64'(full),  64'(q.size() == DEPTH));
    check({tag, ".empty"}, 64'(empty), 64'(q.size() == 0));
    check({tag, ".drop"},  64'(drop_cnt), 64'(m_drop));
    check({tag, ".ovf"},   64'(overflow), 64'(m_ovf));
    if (q.size() != 0) begin
      check({tag, ".pc"},   64'(trace_pc),   64'(q[0].pc));
      check({tag, ".addr"}, 64'(trace_addr), 64'(q[0].addr));
      check({tag, ".data"}, 64'(trace_data), 64'(q[0].data));
    end
  endtask

  task automatic push(input logic [31:0] pc, input logic [4:0] a, input logic [31:0] d);
    wb_en = 1'b1; wb_pc = pc; wb_addr = a; wb_data = d;
    cycle();
    wb_en = 1'b0;
  endtask

  initial begin
    n_pass = 0; n_total = 0; m_drop = '0; m_ovf = 1'b0;
    reset = 1'b1; wb_en = 1'b0; wb_pc = '0; wb_addr = '0; wb_data = '0; trace_ready = 1'b0;

    // Reset held with a capture event pending.
    wb_en = 1'b1; wb_addr = 5'd8; wb_data = 32'h55;
    for (int i = 0; i < 10; i++) cycle();
    reset = 1'b0; wb_en = 1'b0;
    cycle();
    check("rst.valid", 64'(trace_valid), 64'd0);
    check("rst.count", 64'(count), 64'd0);
    check("rst.drop",  64'(drop_cnt), 64'd0);
    check_all("rst");

    // Single push, hold while not ready, then pop.
    push(32'h0000_3000, 5'd8, 32'h1234_5678);
    check("one.pc",   64'(trace_pc),   64'h3000);
    check("one.addr", 64'(trace_addr), 64'd8);
    check("one.data", 64'(trace_data), 64'h1234_5678);
    check("one.count", 64'(count), 64'd1);
    for (int i = 0; i < 5; i++) begin
      cycle();
      check("hold.data", 64'(trace_data), 64'h1234_5678);
      check_all("hold");
    end
    trace_ready = 1'b1;
    cycle();
    trace_ready = 1'b0;
    check("pop.empty", 64'(empty), 64'd1);

    // Nine pushes into eight slots.
    for (int i = 1; i <= 9; i++) push(32'h100 + 32'(i), 5'd3, 32'(i));
    check("ovr.full",  64'(full), 64'd1);
    check("ovr.count", 64'(count), 64'd8);
    check("ovr.drop",  64'(drop_cnt), 64'd1);
    check("ovr.ovf",   64'(overflow), 64'd1);
    trace_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      check("drain.data", 64'(trace_data), 64'(i));
      cycle();
    end
    trace_ready = 1'b0;
    check_all("drained");

    // Full with simultaneous push and pop.
    for (int i = 1; i <= 8; i++) push(32'h200 + 32'(i), 5'd4, 32'h40 + 32'(i));
    trace_ready = 1'b1;
    push(32'h2FF, 5'd4, 32'hA5);
    check("fpp.count", 64'(count), 64'd8);
    check("fpp.drop",  64'(drop_cnt), 64'd1);
    check_all("fpp");
    for (int i = 2; i <= 8; i++) begin
      check("fpp.drain", 64'(trace_data), 64'h40 + 64'(i));
      cycle();
    end
    check("fpp.last", 64'(trace_data), 64'hA5);
    cycle();
    trace_ready = 1'b0;
    check("fpp.empty", 64'(empty), 64'd1);

    // Register-zero filtering on both instances.
    reset = 1'b1; cycle(); reset = 1'b0;
    push(32'h4000, 5'd0, 32'hDEAD);
    check("fz.count", 64'(count), 64'd0);
    check("nf.count", 64'(nf_count), 64'd1);
    check("nf.addr",  64'(nf_addr), 64'd0);
    check("nf.data",  64'(nf_data), 64'hDEAD);

    // Five stored with overflow set, then one reset cycle with a push active.
    reset = 1'b1; cycle(); reset = 1'b0;
    for (int i = 0; i < 9; i++) push(32'h500 + 32'(i), 5'd9, 32'h60 + 32'(i));
    trace_ready = 1'b1;
    for (int i = 0; i < 3; i++) cycle();
    trace_ready = 1'b0;
    check("five.count", 64'(count), 64'd5);
    check("five.ovf",   64'(overflow), 64'd1);
    reset = 1'b1; wb_en = 1'b1; wb_addr = 5'd9; wb_data = 32'h77;
    cycle();
    reset = 1'b0; wb_en = 1'b0;
    check("rp.empty", 64'(empty), 64'd1);
    check("rp.count", 64'(count), 64'd0);
    check("rp.ovf",   64'(overflow), 64'd0);
    check("rp.drop",  64'(drop_cnt), 64'd0);

    // Randomized traffic with a filling phase then a draining phase.
    for (int i = 0; i < 400; i++) begin
      wb_en       = ($urandom_range(0, 9) < 7);
      wb_addr     = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom);
      wb_pc       = $urandom;
      wb_data     = $urandom;
      trace_ready = (i < 200) ? ($urandom_range(0, 9) < 4) : ($urandom_range(0, 9) < 8);
      cycle();
      check_all("rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/wb_trace_fifo.md
WB_TRACE_FIFO -- requirements
Module: wb_trace_fifo

Interface
REQ-001 Parameter DEPTH, default 8, FIFO entry count; power of two, >= 2.
REQ-002 Parameter FILTER_ZERO, default 1; when 1, writes to register 0 are not captured.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 wb_en  input  1  register-file write strobe from the writeback stage.
REQ-006 wb_pc  input  32  PC of the instruction performing the write.
REQ-007 wb_addr  input  5  destination register number.
REQ-008 wb_data  input  32  value written.
REQ-009 trace_ready  input  1  consumer accepts the head entry this cycle.
REQ-010 trace_valid  output  1  head entry present.
REQ-011 trace_pc  output  32  head entry PC.
REQ-012 trace_addr  output  5  head entry register number.
REQ-013 trace_data  output  32  head entry data.
REQ-014 count  output  log2(DEPTH)+1  number of stored entries.
REQ-015 full  output  1  count == DEPTH.
REQ-016 empty  output  1  count == 0.
REQ-017 drop_cnt  output  16  number of dropped write events, saturating.
REQ-018 overflow  output  1  sticky flag, set on first drop.

Function
REQ-019 Capture event: wb_en=1 and not (FILTER_ZERO=1 and wb_addr=0).
REQ-020 Push: a capture event when not full, or when full with a pop in the same cycle; stores {wb_pc, wb_addr, wb_data} at the write pointer.
REQ-021 Pop: trace_valid=1 and trace_ready=1 at the edge; the read pointer advances.
REQ-022 trace_valid = !empty; trace_pc/addr/data show the head entry in first-word-fall-through fashion.
REQ-023 Latency: an entry pushed at edge N is visible on trace_* after edge N when the FIFO was empty.
REQ-024 Outputs hold their value while trace_valid=1 and trace_ready=0.
REQ-025 Entries pop in strict push order.
REQ-026 Pointers wrap modulo DEPTH; count changes by +1 on push only, -1 on pop only, and 0 on both or neither.
REQ-027 Simultaneous push and pop when full: both take effect, count stays DEPTH, no drop.
REQ-028 Simultaneous push and pop when empty: pop is ignored because trace_valid=0; the push takes effect and count becomes 1.
REQ-029 Drop: a capture event when full without a pop; the data is discarded, drop_cnt increments, and overflow is set.
REQ-030 drop_cnt saturates at 0xFFFF and does not wrap.
REQ-031 overflow clears only on reset.
REQ-032 trace_ready while empty has no effect.

Reset
REQ-033 When reset=1 at an edge: pointers=0, count=0, empty=1, full=0, trace_valid=0, drop_cnt=0, overflow=0.
REQ-034 Reset overrides any push or pop in the same cycle; stored entries are discarded.
REQ-035 trace_pc/addr/data are don't-care while trace_valid=0; storage contents need no reset.

Verification
REQ-036 Reset held 10 cycles with wb_en=1, wb_addr=8 -> after release: trace_valid=0, count=0, drop_cnt=0.
REQ-037 One push of pc=0x00003000, addr=8, data=0x12345678 with trace_ready=0 -> next cycle trace_valid=1, the outputs match, count=1; the outputs hold for 5 cycles, then trace_ready=1 for one cycle gives empty=1.
REQ-038 Nine consecutive pushes (data 1..9) with trace_ready=0 and DEPTH=8 -> full=1, count=8, drop_cnt=1, overflow=1; draining yields data 1..8 in order.
REQ-039 FIFO full, with push (data 0xA5) and pop in the same cycle -> count=8, drop_cnt unchanged, 0xA5 appears last on drain.
REQ-040 wb_en=1, wb_addr=0: with FILTER_ZERO=1 -> count unchanged; with FILTER_ZERO=0 -> entry captured with addr=0.
REQ-041 With 5 entries stored and overflow=1, reset pulsed 1 cycle with a push active -> next cycle empty=1, count=0, overflow=0, drop_cnt=0.
